// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI link sequencer.
package tipi_pkg;

  localparam int unsigned LNK_BITS        = 8;
  localparam int unsigned HALF_CYCLES_MAX = 255;
  localparam int unsigned HCNT_W          = 8;
  localparam int unsigned KCNT_W          = 3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_CLK_HI = 3'd2,
    ST_CLK_LO = 3'd3,
    ST_LATCH  = 3'd4,
    ST_DONE   = 3'd5
  } state_e;

  // Request fields captured on accept and held for the whole transfer.
  typedef struct packed {
    logic                rt;
    logic                dc;
    logic [LNK_BITS-1:0] wdata;
  } xfer_cmd_t;

endpackage

// File: rtl/tipi_halfcnt.sv
// Loadable down-counter that marks the last cycle of a link half-period.
module tipi_halfcnt
  import tipi_pkg::*;
#(
  parameter int unsigned W = HCNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         tc_c
);

  logic [W-1:0] cnt_q;

  // Reload on request, otherwise count down and park at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_q <= '0;
    else if (load)           cnt_q <= load_val;
    else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
  end

  assign tc_c = (cnt_q == '0);

endmodule

// File: rtl/tipi_link_seq.sv
// TIPI link sequencer: drives the CPLD shift-register strobes for one byte
// transfer in either direction. Optional abort support: TIPI_LINK_SEQ_ABORT_EN.
module tipi_link_seq
  import tipi_pkg::*;
#(
  parameter int unsigned HALF_CYCLES = 2
) (
  input  logic                sys_clk,
  input  logic                sys_reset_n,
  input  logic                xfer_req,
  input  logic                xfer_rt,
  input  logic                xfer_dc,
  input  logic [LNK_BITS-1:0] xfer_wdata,
`ifdef TIPI_LINK_SEQ_ABORT_EN
  input  logic                xfer_abort,
  output logic                xfer_err,
`endif
  output logic [LNK_BITS-1:0] xfer_rdata,
  output logic                xfer_busy,
  output logic                xfer_done,
  output logic                lnk_clk,
  output logic                lnk_le,
  output logic                lnk_dc,
  output logic                lnk_rt,
  output logic                lnk_dout,
  input  logic                lnk_din
);

  // Out-of-range parameters are clamped to the legal 1..255 range.
  localparam int unsigned HC_EFF = (HALF_CYCLES > HALF_CYCLES_MAX) ? HALF_CYCLES_MAX :
                                   (HALF_CYCLES < 1) ? 1 : HALF_CYCLES;
  localparam logic [HCNT_W-1:0] HC_LOAD = HCNT_W'(HC_EFF - 1);

  state_e              state_q, state_n;
  logic [KCNT_W-1:0]   k_q, k_n, k_p1;
  xfer_cmd_t           cmd_q, cmd_n;
  logic [LNK_BITS-1:0] shreg_q, shreg_n, rdata_n;
  logic                tc_c, hc_load_c, active;
  logic                clk_n, le_n, dc_n, rt_n, dout_n, busy_n, done_n;
`ifdef TIPI_LINK_SEQ_ABORT_EN
  logic                abort_c;
`endif

  // Every state entry restarts the half-period count.
  assign hc_load_c = (state_n != state_q);

  tipi_halfcnt #(.W(HCNT_W)) u_halfcnt (
    .clk      (sys_clk),
    .rst_n    (sys_reset_n),
    .load     (hc_load_c),
    .load_val (HC_LOAD),
    .tc_c     (tc_c)
  );

  // State and datapath registers; link outputs are registered from next-state values.
  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q    <= ST_IDLE;
      k_q        <= '0;
      cmd_q      <= '0;
      shreg_q    <= '0;
      xfer_rdata <= '0;
      xfer_busy  <= 1'b0;
      xfer_done  <= 1'b0;
      lnk_clk    <= 1'b0;
      lnk_le     <= 1'b0;
      lnk_dc     <= 1'b0;
      lnk_rt     <= 1'b0;
      lnk_dout   <= 1'b0;
`ifdef TIPI_LINK_SEQ_ABORT_EN
      xfer_err   <= 1'b0;
`endif
    end else begin
      state_q    <= state_n;
      k_q        <= k_n;
      cmd_q      <= cmd_n;
      shreg_q    <= shreg_n;
      xfer_rdata <= rdata_n;
      xfer_busy  <= busy_n;
      xfer_done  <= done_n;
      lnk_clk    <= clk_n;
      lnk_le     <= le_n;
      lnk_dc     <= dc_n;
      lnk_rt     <= rt_n;
      lnk_dout   <= dout_n;
`ifdef TIPI_LINK_SEQ_ABORT_EN
      xfer_err   <= abort_c;
`endif
    end
  end

  // Next-state sequencing and next values of all registered outputs.
  always_comb begin
    state_n = state_q;
    k_n     = k_q;
    cmd_n   = cmd_q;
    shreg_n = shreg_q;
`ifdef TIPI_LINK_SEQ_ABORT_EN
    abort_c = 1'b0;
`endif

    unique case (state_q)
      ST_IDLE: begin
        if (xfer_req) begin
          cmd_n   = '{rt: xfer_rt, dc: xfer_dc, wdata: xfer_wdata};
          k_n     = '0;
          state_n = ST_SETUP;
        end
      end
      ST_SETUP:  if (tc_c) state_n = ST_CLK_HI;
      ST_CLK_HI: if (tc_c) state_n = ST_CLK_LO;
      ST_CLK_LO: begin
        if (tc_c) begin
          // MSB arrives first: pulse k lands in bit 7-k.
          shreg_n[~k_q] = lnk_din;
          k_n           = k_q + KCNT_W'(1);
          if (k_q == KCNT_W'(LNK_BITS - 1)) state_n = cmd_q.rt ? ST_DONE : ST_LATCH;
          else                              state_n = ST_CLK_HI;
        end
      end
      ST_LATCH:  if (tc_c) state_n = ST_DONE;
      ST_DONE:   state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase

`ifdef TIPI_LINK_SEQ_ABORT_EN
    if (xfer_abort && (state_q != ST_IDLE) && (state_q != ST_DONE)) begin
      state_n = ST_IDLE;
      abort_c = 1'b1;
    end
`endif

    active = (state_n == ST_SETUP) || (state_n == ST_CLK_HI) ||
             (state_n == ST_CLK_LO) || (state_n == ST_LATCH);
    k_p1   = k_n + KCNT_W'(1);

    clk_n  = (state_n == ST_CLK_HI);
    dc_n   = active && cmd_n.dc;
    rt_n   = active && cmd_n.rt;
    // Reads hold LE through the parallel-load pulse; writes strobe it in LATCH.
    le_n   = (state_n == ST_LATCH) ||
             (cmd_n.rt && (k_n == '0) && ((state_n == ST_SETUP) || (state_n == ST_CLK_HI)));
    // The next bit is presented at the falling edge so it is stable across the following high phase.
    dout_n = 1'b0;
    if (!cmd_n.rt) begin
      if ((state_n == ST_SETUP) || (state_n == ST_CLK_HI))
        dout_n = cmd_n.wdata[~k_n];
      else if ((state_n == ST_CLK_LO) && (k_n != KCNT_W'(LNK_BITS - 1)))
        dout_n = cmd_n.wdata[~k_p1];
    end

    busy_n  = (state_n != ST_IDLE);
    done_n  = (state_n == ST_DONE);
    rdata_n = (done_n && cmd_n.rt) ? shreg_n : xfer_rdata;
  end

endmodule
